operand_fifo: RTL and testbench
===============================

// Module: operand_fifo
// PURPOSE
//   Parametrised operand-B buffer for the RISC datapath; successor to the single-word
//   operand register. Queues up to DEPTH operands between decode/register-read and the
//   ALU B input, using valid/ready handshakes on both sides, synchronous flush
//   (branch/abort), and an occupancy count. One clock domain.
// PARAMETERS
//   WIDTH  16  operand width in bits (>=1)
//   DEPTH  4   entries; power of two, >=2
//   CNT_W  derived localparam = $clog2(DEPTH+1); width of count
// PORTS
//   clk        in   1      clock; all state updates on posedge
//   rst_n      in   1      asynchronous, active-low reset
//   flush      in   1      synchronous discard of all entries
//   in_valid   in   1      producer offers in_data this cycle
//   in_data    in   WIDTH  operand to enqueue
//   in_ready   out  1      buffer can accept (= !full)
//   out_valid  out  1      head entry present (= !empty)
//   out_data   out  WIDTH  head entry; 0 when out_valid=0
//   out_ready  in   1      consumer takes head this cycle
//   count      out  CNT_W  entries held, 0..DEPTH
// BEHAVIOUR
//   Reset (rst_n=0, async): wr_ptr=rd_ptr=0, count=0, storage cleared to 0;
//     outputs: in_ready=1, out_valid=0, out_data=0, count=0. Reset is honoured
//     mid-operation; all queued operands are lost, no partial update survives.
//   push = in_valid & in_ready; pop = out_valid & out_ready (both sampled at posedge).
//   in_ready, out_valid and count are decoded from registered state only; no
//     combinational path from in_valid/out_ready to in_ready/out_valid.
//   Latency: operand pushed at edge k is visible on out_data with out_valid=1 after
//     edge k when the buffer was empty (1 cycle); no same-cycle fall-through.
//   Order strictly FIFO. out_data = mem[rd_ptr] when out_valid, else 0.
//   push only: mem[wr_ptr]<=in_data, wr_ptr++, count++.
//   pop only: rd_ptr++, count--.
//   push and pop together (0<count<DEPTH): both pointers advance, count unchanged.
//   Full (count=DEPTH): in_ready=0; in_valid is ignored even if a pop occurs in the
//     same cycle (in_ready is 1 again on the following cycle).
//   Empty (count=0): out_valid=0; out_ready is ignored.
//   Pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty are derived from
//     count, never from pointer equality alone.
//   flush=1 at an edge: pointers and count return to 0; flush takes priority over a
//     simultaneous push/pop, and the offered operand is dropped. Storage is not
//     cleared, but out_data reads 0 because out_valid=0.
//   Data is stored unmodified; no width conversion; count never exceeds DEPTH.
// CONFIGURATION
//   OPB_TRACE_EN defined: at every posedge, $display one line per event:
//     " At this posedge operand B push=%h count=%d", " ... pop=%h ...",
//     " ... flush". Simulation only; synthesis result is unchanged.
//   OPB_TRACE_EN undefined: no $display statements are compiled; RTL otherwise identical.
// TESTING
//   1 Reset: rst_n=0 mid-stream with 3 entries -> immediately count=0, out_valid=0,
//     out_data=0, in_ready=1.
//   2 Push 16'h1111,16'h2222,16'h3333,16'h4444 (DEPTH=4) -> count=4, in_ready=0;
//     5th push 16'h5555 refused; pops return 1111,2222,3333,4444 in order.
//   3 Empty, push 16'hABCD at edge k -> out_valid=1, out_data=ABCD after edge k;
//     pop at k+1 -> count=0, out_data=0.
//   4 count=2, push+pop together for 10 cycles (pointers wrap) -> count stays 2,
//     data emerges in order with no loss or duplication.
//   5 Full, in_valid=1 and out_ready=1 in same cycle -> pop only, count=3; push
//     accepted next cycle.
//   6 count=3, flush=1 together with push 16'hBEEF -> count=0, out_valid=0, BEEF
//     never emitted; subsequent push 16'h0001 is the next out_data.

Source files
------------

// File: rtl/operand_fifo_if.sv
// Operand-B buffer handshake bundle: producer side (in_*), consumer side (out_*),
// synchronous flush and occupancy count. The master modport is the environment
// driving the buffer; the slave modport is the buffer itself.
interface operand_fifo_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/operand_fifo.sv
// Purpose: DEPTH-entry operand-B queue between register-read and the ALU B input.
// Latency: 1 cycle from accepted push to out_valid on an empty buffer; no fall-through.
// Backpressure: in_ready = !full from registered state; a pop never frees a slot in the same cycle.
// Optional: define OPB_TRACE_EN for a per-edge simulation trace of push/pop/flush events.
module operand_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  operand_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Status comes from the count only; pointers alone cannot tell full from empty.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_data  = empty ? '0 : mem[rd_ptr];
  assign bus.count     = count_q;

  assign push = bus.in_valid  & ~full;
  assign pop  = bus.out_ready & ~empty;

  // Storage, pointers and occupancy; flush beats any simultaneous push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.in_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef OPB_TRACE_EN
  // Simulation trace of the events committed at each edge.
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.flush) begin
        $display(" At this posedge operand B flush");
      end else begin
        if (push) $display(" At this posedge operand B push=%h count=%d", bus.in_data, count_q);
        if (pop)  $display(" At this posedge operand B pop=%h count=%d", mem[rd_ptr], count_q);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_operand_fifo.sv
// Bench for operand_fifo: a queue model predicts every output each cycle,
// and directed sequences pin the model with literal expectations.
module tb_operand_fifo;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   chk_en;

  logic [15:0] q[$];

  operand_fifo_if #(.WIDTH(16), .DEPTH(4)) bus ();

  operand_fifo #(.WIDTH(16), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of at most 4 operands.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      bit do_push;
      bit do_pop;
      do_push = bus.in_valid && (q.size() < 4);
      do_pop  = bus.out_ready && (q.size() > 0);
      if (bus.flush) begin
        q.delete();
      end else begin
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(bus.in_data);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_count",     32'(bus.count),     32'(q.size()));
      chk("m_in_ready",  32'(bus.in_ready),  32'(q.size() != 4));
      chk("m_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("m_out_data",  32'(bus.out_data),  (q.size() != 0) ? 32'(q[0]) : 32'h0);
    end
  end

  task automatic step(input bit iv, input logic [15:0] d, input bit ordy, input bit fl);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_count",     32'(bus.count),     32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'h0);
    chk_en = 1'b1;

    // Fill to DEPTH, refuse the fifth, drain in order.
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 1'b0, 1'b0);
    step(1'b1, 16'h4444, 1'b0, 1'b0);
    chk("full_count",    32'(bus.count),    32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    step(1'b1, 16'h5555, 1'b0, 1'b0);
    chk("refused_count", 32'(bus.count), 32'd4);
    begin
      logic [15:0] exp_seq [4];
      exp_seq[0] = 16'h1111; exp_seq[1] = 16'h2222;
      exp_seq[2] = 16'h3333; exp_seq[3] = 16'h4444;
      for (int i = 0; i < 4; i++) begin
        chk("drain_order", 32'(bus.out_data), 32'(exp_seq[i]));
        step(1'b0, 16'h0, 1'b1, 1'b0);
      end
    end
    chk("drained_count", 32'(bus.count), 32'd0);

    // Single-cycle latency on empty; out_ready ignored while empty.
    step(1'b1, 16'hABCD, 1'b1, 1'b0);
    chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_out_data",  32'(bus.out_data),  32'hABCD);
    chk("lat_count",     32'(bus.count),     32'd1);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("lat_pop_count", 32'(bus.count),    32'd0);
    chk("lat_pop_data",  32'(bus.out_data), 32'h0);

    // Steady push+pop at count=2 across pointer wrap.
    step(1'b1, 16'hA000, 1'b0, 1'b0);
    step(1'b1, 16'hA001, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("wrap_data", 32'(bus.out_data), 32'(16'hA000 + 16'(i)));
      step(1'b1, 16'hA002 + 16'(i), 1'b1, 1'b0);
      chk("wrap_count", 32'(bus.count), 32'd2);
    end
    chk("wrap_tail0", 32'(bus.out_data), 32'hA00A);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("wrap_tail1", 32'(bus.out_data), 32'hA00B);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("wrap_empty", 32'(bus.count), 32'd0);

    // Full with simultaneous push and pop: pop only.
    for (int i = 0; i < 4; i++) step(1'b1, 16'hB000 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'hB004, 1'b1, 1'b0);
    chk("fullpp_count", 32'(bus.count),    32'd3);
    chk("fullpp_head",  32'(bus.out_data), 32'hB001);
    step(1'b1, 16'hB004, 1'b0, 1'b0);
    chk("fullpp_next",  32'(bus.count),    32'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("fullpp_order", 32'(bus.out_data), 32'(16'hB000 + 16'(i)));
      step(1'b0, 16'h0, 1'b1, 1'b0);
    end

    // Flush beats a simultaneous push.
    step(1'b1, 16'hC000, 1'b0, 1'b0);
    step(1'b1, 16'hC001, 1'b0, 1'b0);
    step(1'b1, 16'hC002, 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b1);
    chk("flush_count",     32'(bus.count),     32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_out_data",  32'(bus.out_data),  32'h0);
    step(1'b1, 16'h0001, 1'b0, 1'b0);
    chk("flush_next", 32'(bus.out_data), 32'h0001);
    step(1'b0, 16'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream with 3 entries.
    step(1'b1, 16'hD000, 1'b0, 1'b0);
    step(1'b1, 16'hD001, 1'b0, 1'b0);
    step(1'b1, 16'hD002, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(bus.count), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_count",     32'(bus.count),     32'd0);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out_data",  32'(bus.out_data),  32'h0);
    chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 16'hE000, 1'b0, 1'b0);
    chk("post_rst_data", 32'(bus.out_data), 32'hE000);
    idle();
    idle();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
